// File: rtl/lsu_access_ctrl_pkg.sv
// Shared types and constants for the load/store access controller.
package lsu_access_ctrl_pkg;

    // RV32 load width codes
    localparam logic [2:0] LOAD_BYTE   = 3'b000;
    localparam logic [2:0] LOAD_HALF   = 3'b001;
    localparam logic [2:0] LOAD_WORD   = 3'b010;
    localparam logic [2:0] LOAD_BYTE_U = 3'b100;
    localparam logic [2:0] LOAD_HALF_U = 3'b101;

    // RV32 store width codes
    localparam logic [2:0] STORE_BYTE  = 3'b000;
    localparam logic [2:0] STORE_HALF  = 3'b001;
    localparam logic [2:0] STORE_WORD  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD1,
        S_LD2,
        S_ST,
        S_RSP
    } lsu_state_t;

    // Access size in bytes (1, 2 or 4) for a legal width code.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            return !(funct3 inside {STORE_BYTE, STORE_HALF, STORE_WORD});
        return !(funct3 inside {LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_BYTE_U, LOAD_HALF_U});
    endfunction

    // Bytes never straddle; halfwords need addr[0]=0; words need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_access_ctrl_if.sv
// Request/response handshake between the execute stage and the LSU.
interface lsu_access_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    // Execute-stage side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // LSU side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_access_ctrl_load_align.sv
// Load data merge: shifts the {hi,lo} word pair by the byte offset and
// sign/zero-extends to the requested width.
module lsu_load_align
    import lsu_access_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] hi,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    // Byte-shift the merged pair and extend the selected low bits
    always_comb begin
        shifted = XLEN'({hi, lo} >> {offset, 3'b000});
        case (funct3)
            LOAD_BYTE:   data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            LOAD_HALF:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            LOAD_BYTE_U: data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            LOAD_HALF_U: data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default:     data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store sequencer between execute stage and data memory. Splits
// misaligned accesses into aligned memory cycles (two word reads for loads,
// per-byte writes for stores) and returns one response per request.
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned requests with
// rsp_err instead of splitting them.
module lsu_access_ctrl
    import lsu_access_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    lsu_access_ctrl_if.slave  bus,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wd,
    input  logic [XLEN-1:0]   mem_rd
);

    lsu_state_t      state;
    lsu_state_t      state_next;

    logic            r_we;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] hi;
    logic [1:0]      cnt;

    logic            accept;
    logic            in_err;
    logic            r_misal;
    logic            r_err;
    logic [1:0]      st_last_idx;
    logic            st_last;
    logic [XLEN-1:0] load_data;

    assign accept  = bus.req_valid && bus.req_ready;
    assign r_misal = is_misaligned(r_funct3, r_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign in_err = is_illegal(bus.req_we, bus.req_funct3)
                 || is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
    assign r_err  = is_illegal(r_we, r_funct3) || r_misal;
`else
    assign in_err = is_illegal(bus.req_we, bus.req_funct3);
    assign r_err  = is_illegal(r_we, r_funct3);
`endif

    // Aligned stores take one cycle; split stores run bytes 0..N-1
    assign st_last_idx = 2'(access_size(r_funct3) - 3'd1);
    assign st_last     = !r_misal || (cnt == st_last_idx);

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .lo     (lo),
        .hi     (hi),
        .offset (r_addr[1:0]),
        .funct3 (r_funct3),
        .data   (load_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Request latch, read-word capture and store byte counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            lo       <= '0;
            hi       <= '0;
            cnt      <= '0;
        end else begin
            if (accept) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                cnt      <= '0;
            end
            if (state == S_LD1)
                lo <= mem_rd;
            if (state == S_LD2)
                hi <= mem_rd;
            if (state == S_ST && !st_last)
                cnt <= cnt + 2'd1;
        end
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_err)
                        state_next = S_RSP;
                    else if (bus.req_we)
                        state_next = S_ST;
                    else
                        state_next = S_LD1;
                end
            end
            S_LD1:   state_next = r_misal ? S_LD2 : S_RSP;
            S_LD2:   state_next = S_RSP;
            S_ST:    state_next = st_last ? S_RSP : S_ST;
            S_RSP:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Memory port and response outputs; everything idles at zero
    always_comb begin
        bus.req_ready = (state == S_IDLE);
        bus.rsp_valid = (state == S_RSP);
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = '0;
        mem_we        = 1'b0;
        mem_funct3    = '0;
        mem_addr      = '0;
        mem_wd        = '0;
        case (state)
            S_LD1: begin
                // loads always fetch the whole containing word
                mem_funct3 = LOAD_WORD;
                mem_addr   = {r_addr[XLEN-1:2], 2'b00};
            end
            S_LD2: begin
                mem_funct3 = LOAD_WORD;
                mem_addr   = {r_addr[XLEN-1:2], 2'b00} + XLEN'(4);
            end
            S_ST: begin
                mem_we = !reset;
                if (r_misal) begin
                    mem_funct3 = STORE_BYTE;
                    mem_addr   = r_addr + XLEN'(cnt);
                    mem_wd     = {{(XLEN-8){1'b0}}, r_wdata[{cnt, 3'b000} +: 8]};
                end else begin
                    mem_funct3 = r_funct3;
                    mem_addr   = r_addr;
                    mem_wd     = r_wdata;
                end
            end
            S_RSP: begin
                bus.rsp_err   = r_err;
                bus.rsp_rdata = (r_we || r_err) ? '0 : load_data;
            end
            default: ;
        endcase
    end

endmodule
